// File: rtl/instr_fetch_unit.sv
// Fetch/decode front end: PC, 256x32 imem interface, field split, jump/branch/halt control.
// Define FETCH_ILLEGAL_TRAP_EN to halt with illegal=1 on opcode 8'h0e or 8'h10-8'hff.
module instr_fetch_unit #(
  parameter logic [7:0]  RESET_PC    = 8'h00,
  parameter int unsigned INSTR_WIDTH = 32
) (
  input  logic                   Clk,
  input  logic                   Reset,
  output logic                   imem_rdEn,
  output logic [7:0]             imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic                   dec_valid,
  input  logic                   dec_ready,
  output logic [7:0]             dec_op,
  output logic [7:0]             dec_dest,
  output logic [7:0]             dec_src1,
  output logic [7:0]             dec_src2,
  output logic [7:0]             dec_pc,
  input  logic                   br_valid,
  input  logic                   br_taken,
  output logic                   halted,
  output logic                   illegal
);

  typedef enum logic [2:0] {FETCH, LOAD, PRESENT, BR_WAIT, HALT} state_t;

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] addr_q;
  logic       rd_q;
  logic [7:0] op_q, dest_q, src1_q, src2_q, dpc_q;
  logic       op_jmp, op_br, op_halt;
`ifdef FETCH_ILLEGAL_TRAP_EN
  logic       op_bad;
  logic       ill_q, ill_d;
`endif

  always_comb begin
    op_jmp  = (op_q == 8'h08);
    op_br   = (op_q >= 8'h09) && (op_q <= 8'h0b);
    op_halt = (op_q == 8'h0f);
`ifdef FETCH_ILLEGAL_TRAP_EN
    op_bad  = (op_q == 8'h0e) || (op_q >= 8'h10);
`endif
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // FETCH only advances once a read has actually been issued, so the
  // reset-time FETCH (read enable still low) lasts one extra cycle.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
`ifdef FETCH_ILLEGAL_TRAP_EN
    ill_d   = ill_q;
`endif
    unique case (state_q)
      FETCH:   if (rd_q) state_d = LOAD;
      LOAD:    state_d = PRESENT;
      PRESENT: begin
        if (dec_ready) begin
          if (op_jmp) begin
            pc_d    = dest_q;
            state_d = FETCH;
          end else if (op_br) begin
            state_d = BR_WAIT;
          end else if (op_halt) begin
            state_d = HALT;
`ifdef FETCH_ILLEGAL_TRAP_EN
          end else if (op_bad) begin
            state_d = HALT;
            ill_d   = 1'b1;
`endif
          end else begin
            pc_d    = pc_q + 8'd1;
            state_d = FETCH;
          end
        end
      end
      BR_WAIT: begin
        if (br_valid) begin
          pc_d    = br_taken ? dest_q : pc_q + 8'd1;
          state_d = FETCH;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pc_q   <= RESET_PC;
      addr_q <= RESET_PC;
      rd_q   <= 1'b0;
      op_q   <= '0;
      dest_q <= '0;
      src1_q <= '0;
      src2_q <= '0;
      dpc_q  <= '0;
`ifdef FETCH_ILLEGAL_TRAP_EN
      ill_q  <= 1'b0;
`endif
    end else begin
      pc_q <= pc_d;
      rd_q <= (state_d == FETCH);
      if (state_d != HALT) addr_q <= pc_d;
      if (state_q == LOAD) begin
        op_q   <= imem_data[31:24];
        dest_q <= imem_data[23:16];
        src1_q <= imem_data[15:8];
        src2_q <= imem_data[7:0];
        dpc_q  <= pc_q;
      end
`ifdef FETCH_ILLEGAL_TRAP_EN
      ill_q <= ill_d;
`endif
    end
  end

  always_comb begin
    imem_rdEn = rd_q;
    imem_addr = addr_q;
    dec_valid = (state_q == PRESENT);
    halted    = (state_q == HALT);
    dec_op    = op_q;
    dec_dest  = dest_q;
    dec_src1  = src1_q;
    dec_src2  = src2_q;
    dec_pc    = dpc_q;
`ifdef FETCH_ILLEGAL_TRAP_EN
    illegal   = ill_q;
`else
    illegal   = 1'b0;
`endif
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a synchronous 256x32 memory model.
module tb_instr_fetch_unit;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        imem_rdEn;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data = '0;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [7:0]  dec_op, dec_dest, dec_src1, dec_src2, dec_pc;
  logic        br_valid = 1'b0;
  logic        br_taken = 1'b0;
  logic        halted, illegal;

  logic [31:0] mem [256];
  int n_cmp = 0;
  int n_err = 0;
  int rd07  = 0;

  instr_fetch_unit #(.RESET_PC(8'h00), .INSTR_WIDTH(32)) dut (
    .Clk(Clk), .Reset(Reset), .imem_rdEn(imem_rdEn), .imem_addr(imem_addr),
    .imem_data(imem_data), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_op(dec_op), .dec_dest(dec_dest), .dec_src1(dec_src1), .dec_src2(dec_src2),
    .dec_pc(dec_pc), .br_valid(br_valid), .br_taken(br_taken),
    .halted(halted), .illegal(illegal)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (imem_rdEn) begin
      imem_data <= mem[imem_addr];
      if (imem_addr == 8'h07) rd07 <= rd07 + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_present(input logic [7:0] exp_pc);
    int n;
    n = 0;
    while (!dec_valid && n < 8) begin
      tick();
      n++;
    end
    chk("present_valid", {31'd0, dec_valid}, 32'd1);
    chk("present_pc", {24'd0, dec_pc}, {24'd0, exp_pc});
  endtask

  task automatic accept();
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0f000000;
    mem[8'h00] = 32'h0c000933;
    mem[8'h01] = 32'h0c010444;
    mem[8'h02] = 32'h08060000;
    mem[8'h06] = 32'h08100000;
    mem[8'h10] = 32'h0c000000;
    mem[8'h11] = 32'h0b140000;
    mem[8'h12] = 32'h01000001;
    mem[8'h13] = 32'h08190000;
    mem[8'h14] = 32'h08110000;
    mem[8'h19] = 32'h0f000000;

    tick();
    tick();
    chk("rst_rden", {31'd0, imem_rdEn}, 32'd0);
    chk("rst_addr", {24'd0, imem_addr}, 32'h00);
    chk("rst_valid", {31'd0, dec_valid}, 32'd0);
    chk("rst_fields", {dec_op, dec_dest, dec_src1, dec_src2}, 32'h0);
    chk("rst_status", {dec_pc, 6'd0, halted, illegal}, 32'h0);

    // Back-to-back throughput with dec_ready held high.
    Reset = 1'b0;
    dec_ready = 1'b1;
    tick();
    chk("c0_rden", {31'd0, imem_rdEn}, 32'd1);
    chk("c0_addr", {24'd0, imem_addr}, 32'h00);
    tick();
    chk("c1_rden_valid", {30'd0, imem_rdEn, dec_valid}, 32'd0);
    tick();
    chk("c2_valid", {31'd0, dec_valid}, 32'd1);
    chk("c2_dec", {dec_pc, dec_op, dec_src1, dec_src2}, 32'h000c0933);
    tick();
    chk("c3_fetch", {23'd0, imem_rdEn, imem_addr}, 32'h101);
    tick();
    chk("c4_valid", {31'd0, dec_valid}, 32'd0);
    tick();
    chk("c5_valid", {31'd0, dec_valid}, 32'd1);
    chk("c5_dec", {dec_pc, dec_op, dec_dest, dec_src1}, 32'h010c0104);
    dec_ready = 1'b0;
    accept();

    wait_present(8'h02);
    chk("jmp02_op", {24'd0, dec_op}, 32'h08);
    accept();
    wait_present(8'h06);
    chk("jmp06_dest", {24'd0, dec_dest}, 32'h10);
    accept();
    chk("jmp_target", {23'd0, imem_rdEn, imem_addr}, 32'h110);

    wait_present(8'h10);
    accept();
    wait_present(8'h11);
    chk("br_op", {24'd0, dec_op}, 32'h0b);
    dec_ready = 1'b1;
    br_valid = 1'b1;
    br_taken = 1'b0;
    tick();
    dec_ready = 1'b0;
    br_valid = 1'b0;
    chk("brw1", {22'd0, dec_valid, imem_rdEn, imem_addr}, 32'h011);
    tick();
    chk("brw2", {22'd0, dec_valid, imem_rdEn, imem_addr}, 32'h011);
    br_valid = 1'b1;
    br_taken = 1'b1;
    tick();
    br_valid = 1'b0;
    chk("br_taken", {23'd0, imem_rdEn, imem_addr}, 32'h114);

    wait_present(8'h14);
    accept();
    wait_present(8'h11);
    accept();
    br_valid = 1'b1;
    br_taken = 1'b0;
    tick();
    br_valid = 1'b0;
    chk("br_not_taken", {23'd0, imem_rdEn, imem_addr}, 32'h112);

    wait_present(8'h12);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_fields", {dec_op, dec_dest, dec_src1, dec_src2}, 32'h01000001);
      chk("stall_ctl", {dec_pc, 6'd0, dec_valid, imem_rdEn}, 32'h1202);
    end
    accept();
    chk("stall_next", {23'd0, imem_rdEn, imem_addr}, 32'h113);
    wait_present(8'h13);
    accept();
    wait_present(8'h19);
    chk("halt_op", {24'd0, dec_op}, 32'h0f);
    accept();
    chk("halt_st", {28'd0, halted, illegal, dec_valid, imem_rdEn}, 32'h8);
    br_valid = 1'b1;
    br_taken = 1'b1;
    dec_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("halt_hold", {21'd0, halted, dec_valid, imem_rdEn, imem_addr}, 32'h419);
    end
    br_valid = 1'b0;
    dec_ready = 1'b0;
    chk("no_read_07", rd07, 32'd0);

    // Reset mid-PRESENT at a non-reset address.
    Reset = 1'b1;
    tick();
    mem[8'h00] = 32'h08200000;
    mem[8'h20] = 32'h0caabbcc;
    Reset = 1'b0;
    wait_present(8'h00);
    accept();
    wait_present(8'h20);
    chk("p20_fields", {dec_dest, dec_src1, dec_src2}, 32'haabbcc);
    #3;
    Reset = 1'b1;
    #1;
    chk("arst_fields", {dec_op, dec_dest, dec_src1, dec_src2}, 32'h0);
    chk("arst_ctl", {dec_pc, imem_addr, 12'd0, halted, illegal, dec_valid, imem_rdEn}, 32'h0);
    mem[8'h00] = 32'h08ff0000;
    mem[8'hff] = 32'h0e000000;
    tick();
    Reset = 1'b0;
    tick();
    chk("resume_fetch", {23'd0, imem_rdEn, imem_addr}, 32'h100);
    wait_present(8'h00);
    accept();
    wait_present(8'hff);
    chk("ill_op", {24'd0, dec_op}, 32'h0e);
    accept();
`ifdef FETCH_ILLEGAL_TRAP_EN
    chk("trap_st", {28'd0, halted, illegal, dec_valid, imem_rdEn}, 32'hc);
    chk("trap_pc", {24'd0, dec_pc}, 32'hff);
`else
    chk("nop_st", {30'd0, halted, illegal}, 32'h0);
    chk("wrap_addr", {23'd0, imem_rdEn, imem_addr}, 32'h100);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
